mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sole owner of the byte-wide unified RAM port; shares it between instruction fetch (IF) and the load/store buffer (LSB).
- Grants whole transactions, with no mid-transaction preemption. Splits each transaction into byte beats and reassembles read data.
- Applies starvation-bounded priority between the two requesters, IO-store back-pressure, and misprediction flush.
- Sits between IF/LSB and the top-level RAM/IO pins.

Parameters:
- ROB_W, 4, width of ROB id tag.
- STARVE_MAX, 4, max consecutive LSB grants while if_req waits; the next arbitration then goes to IF. Range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global enable; low = freeze
- io_buffer_full  in  1  UART TX buffer full
- flush  in  1  misprediction flush, one-cycle pulse
- mem_din  in  8  RAM read byte; reflects the address of the previous cycle
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write, 0 = read
- if_req  in  1  fetch request; held until if_done
- if_addr  in  32  fetch word address
- if_done  out  1  one-cycle pulse; if_data valid
- if_data  out  32  fetched instruction, little-endian
- ls_req  in  1  LSB request; held until ls_done
- ls_we  in  1  0 = load, 1 = store
- ls_width  in  2  bytes minus 1: 0, 1 or 3 (2 is illegal)
- ls_addr  in  32  byte address
- ls_wdata  in  32  store data, low bytes used
- ls_rob_id  in  ROB_W  tag of the load
- ls_done  out  1  one-cycle pulse; transaction complete
- ld_valid  out  1  one-cycle pulse with ls_done for loads; CDB broadcast
- ld_data  out  32  zero-extended load result
- ld_rob_id  out  ROB_W  tag of the completing load
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset, asynchronous on rst_n low:
  - state IDLE; step = 0; starve_cnt = 0.
  - All outputs 0, including mem_a, mem_wr, data and tag outputs.
- States: IDLE, RUN_IF, RUN_LS, DONE.
- RAM outputs are registered. mem_wr is additionally gated combinationally: 0 whenever rdy = 0 or state is IDLE or DONE.
- Arbitration happens in IDLE at an edge with rdy = 1 and flush = 0:
  - Only IF requests: grant IF.
  - Only LSB requests: grant LSB.
  - Both request: grant IF if starve_cnt == STARVE_MAX, otherwise grant LSB.
  - Each LSB grant with if_req high increments starve_cnt. An IF grant clears it.
- Beats: let N = 4 for IF, or ls_width + 1 for LSB. Requests are sampled at edge E0.
  - Byte i is driven on mem_a = base + i after edge E0 + i.
  - For reads, byte i is captured at edge E0 + i + 1 into bits [8i+7:8i].
  - After edge E0 + N: state = DONE and the done pulse is high, with if_data or ld_data/ld_rob_id registered.
  - Loads and fetches therefore take N + 1 cycles from grant to done. Stores signal done at the same point.
- DONE lasts exactly one cycle and ignores requests, giving the requester a cycle to drop req. It then returns to IDLE.
- Minimum spacing between grants is N + 2 cycles.
- Address arithmetic is 32-bit with wrap-around; base + i wraps modulo 2^32.
- IO store: when ls_we = 1 and ls_addr[17:16] == 2'b11, each beat issues only if io_buffer_full = 0.
  - Otherwise the beat holds address and step, and mem_wr = 0.
- IO load: issued normally, one byte. It is never re-issued except as a consequence of a rdy stall.
- rdy = 0: state, step, counters and registered outputs all freeze. mem_wr is forced to 0 and no byte is captured.
  - On resume the same beat is re-driven. A read beat is re-captured.
- flush during RUN_IF, or during RUN_LS with a load: abort.
  - Next state IDLE, step = 0. No done pulse; partial data is discarded.
- flush during a DONE cycle for IF or load: the done, ld_valid and if_done pulses are suppressed (gated combinationally).
- flush during a store, in any state: ignored. The store completes and ls_done is pulsed, because stores are already committed.
- flush and a new request arriving in IDLE in the same cycle: no grant that cycle.
- ls_width = 2 is illegal. The bench asserts it never occurs; RTL treats it as 3.

Decomposition:
- Shared package mem_pkg holds:
  - state enum (IDLE, RUN_IF, RUN_LS, DONE);
  - width encodings W_BYTE = 0, W_HALF = 1, W_WORD = 3;
  - IO region constant (addr[17:16] == 2'b11) and an is_io(addr) function.
- One sub-module, mem_byte_seq, holds:
  - step counter, base/length latch, address generation;
  - write-byte mux and read-byte assembly register.
- The arbiter keeps the FSM, starvation counter, flush and IO gating.

Test Plan:
- IF only, if_addr = 0x100, RAM bytes 13 05 00 00 → mem_a 0x100..0x103 on consecutive cycles; if_done 5 cycles after grant with if_data = 0x00000513; busy low 1 cycle later.
- Both requesting continuously, STARVE_MAX = 4, LSB 1-byte loads → grant order L L L L I L L L L I; starve_cnt returns to 0 after each IF grant.
- Store half-word 0xBEEF to 0x2002 → mem_wr high for 2 cycles, (0x2002, EF) then (0x2003, BE); ls_done with no ld_valid.
- IO store 'A' to 0x30000 with io_buffer_full high for 3 cycles → mem_wr stays 0 for 3 cycles, then a single write of 0x41; ls_done follows.
- flush during beat 2 of a word load with rob_id 7 → no ls_done or ld_valid; state IDLE next cycle. The same flush during a word store → all 4 bytes written and ls_done pulsed.
- rdy low for 2 cycles mid-fetch, plus asynchronous rst_n pulse mid-load → fetch completes with correct data, with mem_wr = 0 during the pause; the reset clears all outputs and busy immediately without waiting for a clock.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the unified RAM port arbiter.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, RUN_IF, RUN_LS, DONE} state_t;

  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd3;

  localparam logic [1:0] IO_REGION = 2'b11;

  function automatic logic is_io(input logic [31:0] addr);
    return addr[17:16] == IO_REGION;
  endfunction

  // Width code 2 never legally occurs; it is widened to a full word.
  function automatic logic [1:0] last_beat(input logic [1:0] width);
    return (width == 2'd2) ? W_WORD : width;
  endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte-beat sequencer: walks base..base+len on the RAM port, muxes store bytes
// and assembles read bytes little-endian.
module mem_byte_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        start,
  input  logic        advance,
  input  logic        clear,
  input  logic [31:0] start_addr,
  input  logic [1:0]  start_len,
  input  logic [31:0] start_wdata,
  input  logic [7:0]  mem_din,
  output logic [31:0] mem_a,
  output logic [7:0]  mem_dout,
  output logic        last,
  output logic [31:0] rdata_next
);

  logic [31:0] base;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [1:0]  len;
  logic [1:0]  step;
  logic [1:0]  step_nx;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  assign step_nx = step + 2'd1;
  assign last    = (step == len);

  always_comb begin
    rdata_next = rdata;
    case (step)
      2'd0:    rdata_next[7:0]   = mem_din;
      2'd1:    rdata_next[15:8]  = mem_din;
      2'd2:    rdata_next[23:16] = mem_din;
      default: rdata_next[31:24] = mem_din;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base     <= '0;
      wdata    <= '0;
      rdata    <= '0;
      len      <= '0;
      step     <= '0;
      mem_a    <= '0;
      mem_dout <= '0;
    end else if (en) begin
      if (start) begin
        base     <= start_addr;
        wdata    <= start_wdata;
        len      <= start_len;
        rdata    <= '0;
        step     <= '0;
        mem_a    <= start_addr;
        mem_dout <= start_wdata[7:0];
      end else if (advance) begin
        rdata <= rdata_next;
        if (last) begin
          step <= '0;
        end else begin
          step     <= step_nx;
          mem_a    <= base + {30'd0, step_nx};
          mem_dout <= byte_of(wdata, step_nx);
        end
      end else if (clear) begin
        step <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Whole-transaction arbiter between instruction fetch and the load/store buffer
// on the byte-wide RAM port, with starvation bound, IO back-pressure and flush.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ROB_W      = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             io_buffer_full,
  input  logic             flush,
  input  logic [7:0]       mem_din,
  output logic [7:0]       mem_dout,
  output logic [31:0]      mem_a,
  output logic             mem_wr,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  output logic             if_done,
  output logic [31:0]      if_data,
  input  logic             ls_req,
  input  logic             ls_we,
  input  logic [1:0]       ls_width,
  input  logic [31:0]      ls_addr,
  input  logic [31:0]      ls_wdata,
  input  logic [ROB_W-1:0] ls_rob_id,
  output logic             ls_done,
  output logic             ld_valid,
  output logic [31:0]      ld_data,
  output logic [ROB_W-1:0] ld_rob_id,
  output logic             busy
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t           state;
  logic [3:0]       starve_cnt;
  logic             wr_q;
  logic             is_store;
  logic             io_store;
  logic [ROB_W-1:0] rob_q;
  logic             if_done_q;
  logic             ls_done_q;
  logic             ld_valid_q;

  logic        grant_if;
  logic        start;
  logic        running;
  logic        abort;
  logic        io_block;
  logic        advance;
  logic        last;
  logic [31:0] rdata_next;

  assign grant_if = if_req && (!ls_req || starve_cnt == STARVE_LIM);
  assign start    = (state == IDLE) && rdy && !flush && (if_req || ls_req);
  assign running  = (state == RUN_IF) || (state == RUN_LS);
  assign abort    = running && flush && !is_store;
  assign io_block = io_store && io_buffer_full;
  assign advance  = rdy && running && !abort && !io_block;

  assign mem_wr   = wr_q && rdy && running && !io_block;
  assign busy     = (state != IDLE);
  // Committed stores must still report completion through a flush.
  assign if_done  = if_done_q && !flush;
  assign ld_valid = ld_valid_q && !flush;
  assign ls_done  = ls_done_q && !(flush && !is_store);

  mem_byte_seq u_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (rdy),
    .start       (start),
    .advance     (advance),
    .clear       (abort),
    .start_addr  (grant_if ? if_addr : ls_addr),
    .start_len   (grant_if ? W_WORD : last_beat(ls_width)),
    .start_wdata (ls_wdata),
    .mem_din     (mem_din),
    .mem_a       (mem_a),
    .mem_dout    (mem_dout),
    .last        (last),
    .rdata_next  (rdata_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      wr_q       <= 1'b0;
      is_store   <= 1'b0;
      io_store   <= 1'b0;
      rob_q      <= '0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      ld_valid_q <= 1'b0;
      if_data    <= '0;
      ld_data    <= '0;
      ld_rob_id  <= '0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          if (start) begin
            if (grant_if) begin
              state      <= RUN_IF;
              starve_cnt <= '0;
              wr_q       <= 1'b0;
              is_store   <= 1'b0;
              io_store   <= 1'b0;
            end else begin
              state    <= RUN_LS;
              wr_q     <= ls_we;
              is_store <= ls_we;
              io_store <= ls_we && is_io(ls_addr);
              rob_q    <= ls_rob_id;
              if (if_req) starve_cnt <= starve_cnt + 4'd1;
            end
          end
        end
        RUN_IF, RUN_LS: begin
          if (abort) begin
            state <= IDLE;
            wr_q  <= 1'b0;
          end else if (advance && last) begin
            state <= DONE;
            wr_q  <= 1'b0;
            if (state == RUN_IF) begin
              if_done_q <= 1'b1;
              if_data   <= rdata_next;
            end else begin
              ls_done_q <= 1'b1;
              if (!is_store) begin
                ld_valid_q <= 1'b1;
                ld_data    <= rdata_next;
                ld_rob_id  <= rob_q;
              end
            end
          end
        end
        default: begin
          state      <= IDLE;
          if_done_q  <= 1'b0;
          ls_done_q  <= 1'b0;
          ld_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
